// File: rtl/debug_pkg.sv
// Shared command/status byte codes and FSM state encoding for the debug sequencer.
// No logic, no latency; pure definitions.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h43;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_RSTPC = 8'h52;

  localparam logic [7:0] STS_ACK  = 8'h4B;
  localparam logic [7:0] STS_ERR  = 8'h45;
  localparam logic [7:0] STS_HALT = 8'h48;
  localparam logic [7:0] STS_STEP = 8'h53;
  localparam logic [7:0] STS_TMO  = 8'h54;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LD_CNT    = 4'd1,
    LD_BYTE   = 4'd2,
    LD_WRITE  = 4'd3,
    LD_DONE   = 4'd4,
    ACK       = 4'd5,
    RUN       = 4'd6,
    STEP      = 4'd7,
    DUMP_ADDR = 4'd8,
    DUMP_WAIT = 4'd9,
    DUMP_SEND = 4'd10
  } state_t;

endpackage

// File: rtl/dbg_word_tx.sv
// Serialises 1 or 4 bytes of a word MSB first; first byte offered the cycle after i_load.
// Holds data until i_tx_ready; o_done pulses the cycle after the last transfer.
module dbg_word_tx #(
  parameter int NB_WORD = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_WORD-1:0] i_word,
  input  logic [2:0]         i_count,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_done
);

  logic [NB_WORD-1:0] shreg;
  logic [NB_WORD-1:0] first_word;
  logic [2:0]         remain;

  // A single-byte send takes the low byte, moved up to the outgoing position.
  always_comb begin
    first_word = i_word;
    if (i_count == 3'd1) first_word = {i_word[NB_BYTE-1:0], {(NB_WORD-NB_BYTE){1'b0}}};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shreg      <= '0;
      remain     <= '0;
      o_tx_valid <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_load) begin
        shreg      <= first_word;
        remain     <= i_count;
        o_tx_valid <= 1'b1;
      end else if (o_tx_valid && i_tx_ready) begin
        shreg  <= {shreg[NB_WORD-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
        remain <= remain - 3'd1;
        if (remain == 3'd1) begin
          o_tx_valid <= 1'b0;
          o_done     <= 1'b1;
        end
      end
    end
  end

  assign o_tx_data = shreg[NB_WORD-1 -: NB_BYTE];

endmodule

// File: rtl/debug_sequencer.sv
// Debug-link controller: loads imem, runs/steps/stops the pipeline, dumps regs and dmem.
// Commands act on the edge sampling i_rx_valid; tx backpressure stalls only the dump/ack.
module debug_sequencer #(
  parameter int NB_REG       = 32,
  parameter int NB_BYTE      = 8,
  parameter int N_IMEM_WORDS = 128,
  parameter int N_DMEM_DUMP  = 32,
  parameter int MAX_CYCLES   = 1048576
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  input  logic              i_halt,
  input  logic [NB_REG-1:0] i_dunit_reg,
  input  logic [NB_REG-1:0] i_dunit_mem_data,
  output logic              o_dunit_clk_en,
  output logic              o_dunit_reset_pc,
  output logic              o_dunit_w_mem,
  output logic [NB_REG-1:0] o_dunit_addr,
  output logic [NB_REG-1:0] o_dunit_data_if,
  output logic [3:0]        o_state
);

  import debug_pkg::*;

  localparam int N_REGS = 32;
  localparam int N_DUMP = N_REGS + N_DMEM_DUMP;
  localparam int CNT_W  = $clog2(MAX_CYCLES + 1);
  localparam int DI_W   = $clog2(N_DUMP);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [DI_W-1:0]  DI_LAST  = DI_W'(N_DUMP - 1);
  localparam logic [DI_W-1:0]  DI_REGS  = DI_W'(N_REGS);

  state_t state, next_state;

  logic [NB_BYTE-1:0] word_last;
  logic [NB_BYTE-1:0] wr_idx;
  logic [1:0]         byte_idx;
  logic [NB_REG-1:0]  asm_word;
  logic [CNT_W-1:0]   cyc;
  logic [DI_W-1:0]    di;
  logic               sts_pend;

  logic              tx_load;
  logic [NB_REG-1:0] tx_word;
  logic [2:0]        tx_count;
  logic              tx_done;

  logic [NB_REG-1:0] dump_addr;
  logic [NB_REG-1:0] dump_word;
  logic              bad_count;

  dbg_word_tx #(
    .NB_WORD (NB_REG),
    .NB_BYTE (NB_BYTE)
  ) u_tx (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (tx_load),
    .i_word     (tx_word),
    .i_count    (tx_count),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_done     (tx_done)
  );

  assign bad_count = (i_rx_data == '0) || (int'(i_rx_data) > N_IMEM_WORDS);
  assign o_state   = state;

  // Dump walks registers by index, then data memory by byte address.
  always_comb begin
    dump_addr = '0;
    dump_word = i_dunit_reg;
    if (di < DI_REGS) begin
      dump_addr = NB_REG'(di);
    end else begin
      dump_addr = NB_REG'({di - DI_REGS, 2'b00});
      dump_word = i_dunit_mem_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state       = state;
    o_dunit_clk_en   = 1'b0;
    o_dunit_w_mem    = 1'b0;
    o_dunit_reset_pc = 1'b0;
    o_dunit_addr     = '0;
    o_dunit_data_if  = '0;
    tx_load          = 1'b0;
    tx_word          = '0;
    tx_count         = 3'd1;
    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD:  next_state = LD_CNT;
            CMD_RUN:   next_state = RUN;
            CMD_STEP:  next_state = STEP;
            CMD_RSTPC: next_state = LD_DONE;
            default:   next_state = IDLE;
          endcase
        end
      end
      LD_CNT: begin
        if (i_rx_valid) begin
          if (bad_count) begin
            tx_load    = 1'b1;
            tx_word    = NB_REG'(STS_ERR);
            next_state = ACK;
          end else begin
            next_state = LD_BYTE;
          end
        end
      end
      LD_BYTE: begin
        if (i_rx_valid && byte_idx == 2'd3) next_state = LD_WRITE;
      end
      LD_WRITE: begin
        o_dunit_w_mem   = 1'b1;
        o_dunit_addr    = NB_REG'({wr_idx, 2'b00});
        o_dunit_data_if = asm_word;
        next_state      = (wr_idx == word_last) ? LD_DONE : LD_BYTE;
      end
      LD_DONE: begin
        o_dunit_reset_pc = 1'b1;
        tx_load          = 1'b1;
        tx_word          = NB_REG'(STS_ACK);
        next_state       = ACK;
      end
      ACK: begin
        if (tx_done) next_state = IDLE;
      end
      RUN: begin
        // Halt is checked first so it wins over the watchdog.
        if (i_halt) begin
          tx_load    = 1'b1;
          tx_word    = NB_REG'(STS_HALT);
          next_state = DUMP_SEND;
        end else begin
          o_dunit_clk_en = 1'b1;
          if (cyc == CYC_LAST) begin
            tx_load    = 1'b1;
            tx_word    = NB_REG'(STS_TMO);
            next_state = DUMP_SEND;
          end
        end
      end
      STEP: begin
        o_dunit_clk_en = !i_halt;
        tx_load        = 1'b1;
        tx_word        = i_halt ? NB_REG'(STS_HALT) : NB_REG'(STS_STEP);
        next_state     = DUMP_SEND;
      end
      DUMP_ADDR: begin
        o_dunit_addr = dump_addr;
        next_state   = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        o_dunit_addr = dump_addr;
        tx_load      = 1'b1;
        tx_word      = dump_word;
        tx_count     = 3'd4;
        next_state   = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (tx_done) begin
          if (!sts_pend && di == DI_LAST) next_state = IDLE;
          else                            next_state = DUMP_ADDR;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      word_last <= '0;
      wr_idx    <= '0;
      byte_idx  <= '0;
      asm_word  <= '0;
      cyc       <= '0;
      di        <= '0;
      sts_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wr_idx   <= '0;
          byte_idx <= '0;
          cyc      <= '0;
        end
        LD_CNT: begin
          if (i_rx_valid) word_last <= i_rx_data - NB_BYTE'(1);
        end
        LD_BYTE: begin
          if (i_rx_valid) begin
            asm_word <= {asm_word[NB_REG-NB_BYTE-1:0], i_rx_data};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        LD_WRITE: wr_idx <= wr_idx + NB_BYTE'(1);
        RUN: begin
          di       <= '0;
          sts_pend <= 1'b1;
          if (!i_halt) cyc <= cyc + 1'b1;
        end
        STEP: begin
          di       <= '0;
          sts_pend <= 1'b1;
        end
        DUMP_SEND: begin
          if (tx_done) begin
            if (sts_pend) sts_pend <= 1'b0;
            else          di       <= di + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_sequencer.sv
// Bench for debug_sequencer: command table plus hand-written load/reset sequences.
module tb_debug_sequencer;
  import debug_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;
  logic [31:0] dunit_reg, dunit_mem_data;
  logic        clk_en, reset_pc, w_mem;
  logic [31:0] addr, data_if;
  logic [3:0]  state;

  debug_sequencer #(.MAX_CYCLES(16)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_rx_data        (rx_data),
    .i_rx_valid       (rx_valid),
    .o_tx_data        (tx_data),
    .o_tx_valid       (tx_valid),
    .i_tx_ready       (tx_ready),
    .i_halt           (halt),
    .i_dunit_reg      (dunit_reg),
    .i_dunit_mem_data (dunit_mem_data),
    .o_dunit_clk_en   (clk_en),
    .o_dunit_reset_pc (reset_pc),
    .o_dunit_w_mem    (w_mem),
    .o_dunit_addr     (addr),
    .o_dunit_data_if  (data_if),
    .o_state          (state)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [32];
  logic [31:0] dmem [32];
  assign dunit_reg      = regs[addr[4:0]];
  assign dunit_mem_data = dmem[addr[6:2]];

  int total = 0;
  int bad   = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int   en_cnt, rst_cnt, cur_ha;
  bit   bp_mode;
  logic hold;
  logic [7:0] hold_dat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("tx_hold_data", {24'd0, tx_data}, {24'd0, hold_dat});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("tx_extra_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
        else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      hold     = tx_valid && !tx_ready;
      hold_dat = tx_data;
      if (clk_en) en_cnt++;
      if (reset_pc) rst_cnt++;
      if (w_mem) begin
        if (wr_addr_q.size() == 0) chk("unexpected_write", addr, 32'hFFFF_FFFF);
        else begin
          chk("wr_addr", addr, wr_addr_q.pop_front());
          chk("wr_data", data_if, wr_data_q.pop_front());
        end
      end
    end
  end

  initial begin
    int ph = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        ph++;
        if (ph == 3) begin ph = 0; tx_ready = !tx_ready; end
      end else begin
        tx_ready = 1'b1;
        ph = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && state == 4'd0) && n < 6000) begin
      @(posedge clk); #1;
      if (cur_ha > 0 && en_cnt >= cur_ha) halt = 1'b1;
      n++;
    end
    chk(name, (n < 6000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  function automatic void push_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) exp_q.push_back(w[8*k +: 8]);
  endfunction

  function automatic void push_dump(input logic [7:0] sts);
    exp_q.push_back(sts);
    for (int r = 0; r < 32; r++) push_word(regs[r]);
    for (int m = 0; m < 32; m++) push_word(dmem[m]);
  endfunction

  task automatic chk_all_zero();
    chk("rst_tx_valid", {31'd0, tx_valid}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_clk_en", {31'd0, clk_en}, 0);
    chk("rst_reset_pc", {31'd0, reset_pc}, 0);
    chk("rst_w_mem", {31'd0, w_mem}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data_if", data_if, 0);
    chk("rst_state", {28'd0, state}, 0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    int         arg;
    int         halt_after;
    bit         bp;
    int         exp_en;
    int         exp_rst;
    logic [7:0] exp_sts;
    bit         dump;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] c, input int a, input int ha, input bit b,
                              input int en, input int rp, input logic [7:0] s, input bit d);
    vec_t v;
    v.cmd = c; v.arg = a; v.halt_after = ha; v.bp = b;
    v.exp_en = en; v.exp_rst = rp; v.exp_sts = s; v.dump = d;
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    vec_t v;
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'hA500_0000 + 32'(i * 257);
      dmem[i] = 32'h3C00_0000 ^ 32'(i * 32'h0101_0103);
    end
    regs[1] = 32'h0000_0005;

    // cmd, arg, halt_after, backpressure, clk_en cycles, reset_pc pulses, status, full dump
    vecs[0]  = mk(CMD_LOAD,  0,    -1, 0, 0,  0, STS_ERR,  0);
    vecs[1]  = mk(CMD_LOAD,  8'h81, -1, 0, 0, 0, STS_ERR,  0);
    vecs[2]  = mk(CMD_RSTPC, -1,   -1, 0, 0,  1, STS_ACK,  0);
    vecs[3]  = mk(CMD_RUN,   -1,    7, 0, 7,  0, STS_HALT, 1);
    vecs[4]  = mk(CMD_STEP,  -1,   -1, 0, 1,  0, STS_STEP, 1);
    vecs[5]  = mk(CMD_STEP,  -1,   -1, 0, 1,  0, STS_STEP, 1);
    vecs[6]  = mk(CMD_STEP,  -1,   -1, 0, 1,  0, STS_STEP, 1);
    vecs[7]  = mk(CMD_STEP,  -1,    0, 0, 0,  0, STS_HALT, 1);
    vecs[8]  = mk(CMD_RUN,   -1,   -1, 0, 16, 0, STS_TMO,  1);
    vecs[9]  = mk(CMD_RUN,   -1,    0, 0, 0,  0, STS_HALT, 1);
    vecs[10] = mk(CMD_STEP,  -1,   -1, 1, 1,  0, STS_STEP, 1);
    vecs[11] = mk(8'h5A,     -1,   -1, 0, 0,  0, 8'h00,    0);

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; halt = 1'b0;
    bp_mode = 1'b0; en_cnt = 0; rst_cnt = 0; cur_ha = -1; hold = 1'b0;
    #22;
    chk_all_zero();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Load two words, with exact timing of last write, reset_pc and 'K'.
    wr_addr_q.push_back(32'h0); wr_data_q.push_back(32'h2001_0005);
    wr_addr_q.push_back(32'h4); wr_data_q.push_back(32'hFC00_0000);
    exp_q.push_back(STS_ACK);
    send_byte(CMD_LOAD);
    send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hFC); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    chk("ld_last_wmem", {31'd0, w_mem}, 1);
    @(negedge clk);
    chk("ld_resetpc_pulse", {31'd0, reset_pc}, 1);
    chk("ld_resetpc_nowr", {31'd0, w_mem}, 0);
    @(negedge clk);
    chk("ld_ack_valid", {31'd0, tx_valid}, 1);
    chk("ld_ack_data", {24'd0, tx_data}, {24'd0, STS_ACK});
    chk("ld_resetpc_end", {31'd0, reset_pc}, 0);
    wait_done("ld_timeout");
    chk("ld_writes_left", 32'(wr_addr_q.size()), 0);
    chk("ld_resetpc_count", 32'(rst_cnt), 1);

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      en_cnt = 0; rst_cnt = 0;
      bp_mode = v.bp;
      cur_ha = v.halt_after;
      halt = (v.halt_after == 0);
      if (v.exp_sts != 8'h00) begin
        if (v.dump) push_dump(v.exp_sts);
        else exp_q.push_back(v.exp_sts);
      end
      send_byte(v.cmd);
      if (v.arg >= 0) send_byte(8'(v.arg));
      wait_done($sformatf("vec%0d_timeout", i));
      idle(4);
      chk($sformatf("vec%0d_clk_en_cycles", i), 32'(en_cnt), 32'(v.exp_en));
      chk($sformatf("vec%0d_reset_pc", i), 32'(rst_cnt), 32'(v.exp_rst));
      chk($sformatf("vec%0d_idle", i), {28'd0, state}, 0);
      halt = 1'b0; bp_mode = 1'b0; cur_ha = -1;
    end

    // Reset mid-load: the partial word must never be written.
    send_byte(CMD_LOAD); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    rst = 1'b1; #1;
    chk("ldrst_state", {28'd0, state}, 0);
    chk("ldrst_wmem", {31'd0, w_mem}, 0);
    idle(2);
    rst = 1'b0;
    idle(6);
    chk("ldrst_idle", {28'd0, state}, 0);

    // Reset mid-dump aborts at once, then 'R' still answers 'K'.
    push_dump(STS_STEP);
    send_byte(CMD_STEP);
    begin
      int n = 0;
      while (exp_q.size() > 230 && n < 2000) begin @(posedge clk); #1; n++; end
      chk("dump_progress", (n < 2000) ? 32'd1 : 32'd0, 32'd1);
    end
    rst = 1'b1; #1;
    chk_all_zero();
    exp_q.delete();
    idle(3);
    chk_all_zero();
    rst = 1'b0;
    en_cnt = 0; rst_cnt = 0;
    exp_q.push_back(STS_ACK);
    send_byte(CMD_RSTPC);
    wait_done("rpc_timeout");
    idle(3);
    chk("rpc_reset_pc", 32'(rst_cnt), 1);
    chk("rpc_no_clk_en", 32'(en_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
